// File: rtl/div_out_sched.sv
// rtl/div_out_sched.sv - round-robin arbiter feeding one 8-byte result serializer
// Accepts one 65-bit signed result at a time and holds it stable for the whole frame.
module div_out_sched #(
  parameter int N_REQ = 4,
  parameter int FRAME = 8,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*65-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               ser_en,
  output logic [64:0]        ser_data,
  output logic [PW-1:0]      grant_id,
  output logic               busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ser_en_q, ser_en_d;
  logic [64:0]   ser_data_q, ser_data_d;
  logic [PW-1:0] grant_q, grant_d;

  logic          found;
  logic [PW-1:0] win;
  logic [PW:0]   idx_w;
  logic [PW-1:0] idx;
  logic          accept;

  // Scan upward from ptr, wrapping modulo N_REQ; the first pending channel wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_w = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_w = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx_w >= (PW+1)'(N_REQ)) begin
        idx_w = idx_w - (PW+1)'(N_REQ);
      end
      idx = idx_w[PW-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept    = (state_q == IDLE) && found;
  assign req_ready = (rst_n && accept) ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ser_en_d   = 1'b0;
    ser_data_d = ser_data_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = SHIFT;
          cnt_d      = 3'd0;
          ptr_d      = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
          ser_en_d   = 1'b1;
          ser_data_d = req_data[win*65 +: 65];
          grant_d    = win;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 3'd1;
        // Leaving one cycle early lets the next accept land on the serializer's frame boundary.
        if (cnt_q == 3'(FRAME-2)) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      ptr_q      <= '0;
      ser_en_q   <= 1'b0;
      ser_data_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ser_en_q   <= ser_en_d;
      ser_data_q <= ser_data_d;
      grant_q    <= grant_d;
    end
  end

  assign ser_en   = ser_en_q;
  assign ser_data = ser_data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_div_out_sched.sv
// tb/tb_div_out_sched.sv - randomized self-checking bench for div_out_sched
// Reference model tracks time since the last start pulse and a round-robin start index.
module tb_div_out_sched;
  localparam int N = 4;
  localparam int W = 65;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           ser_en;
  logic [W-1:0]   ser_data;
  logic [1:0]     grant_id;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_out_sched #(.N_REQ(N), .FRAME(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_en(ser_en), .ser_data(ser_data),
    .grant_id(grant_id), .busy(busy)
  );

  int           cyc = 0;
  int           last_en = 0;
  bit           have_en = 0;
  int           rr = 0;
  logic [W-1:0] m_data = '0;
  int           m_gid = 0;
  logic [N-1:0] exp_ready;
  bit           exp_en, exp_busy;
  int           exp_win;

  function automatic logic [W-1:0] chan(int i);
    return req_data[i*W +: W];
  endfunction

  task automatic model_eval();
    exp_ready = '0;
    exp_win   = -1;
    exp_en    = rst_n && have_en && (cyc == last_en);
    exp_busy  = rst_n && have_en && (cyc - last_en < 7);
    if (rst_n && !exp_busy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (exp_win < 0 && req_valid[c]) exp_win = c;
      end
    end
    if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
  endtask

  task automatic model_reset();
    have_en = 0;
    rr      = 0;
    m_data  = '0;
    m_gid   = 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    cyc++;
    if (rst_n && exp_win >= 0) begin
      m_data  = chan(exp_win);
      m_gid   = exp_win;
      rr      = (exp_win + 1) % N;
      last_en = cyc;
      have_en = 1;
    end
    #1;
  endtask

  task automatic sample();
    #2;
    model_eval();
  endtask

  task automatic idle_wait();
    int k;
    k = 0;
    req_valid = '0;
    sample();
    while (exp_busy && k < 20) begin
      tick();
      sample();
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait busy=%b want=0", busy);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = '0;
    req_data = '0;
    #1;
    rst_n = 1'b0;
    model_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = {$urandom, $urandom, 1'b1};
    #2;
    checks += 5;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    if (ser_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b want=0", ser_en); end
    if (ser_data !== 65'd0) begin errors++; $display("FAIL reset_data got=%h want=0", ser_data); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got=%0d want=0", grant_id); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    sample();
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_release busy=%b ready=%b want 0/0000", busy, req_ready);
    end
    tick();
  endtask

  task automatic test_single();
    logic [W-1:0] word;
    logic [7:0]   bytes [8];
    bytes = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    word = {1'b1, 64'h0123_4567_89AB_CDEF};
    idle_wait();
    req_data[2*W +: W] = word;
    req_valid = 4'b0100;
    sample();
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    tick();
    req_valid = '0;
    sample();
    checks += 4;
    if (ser_en !== 1'b1) begin errors++; $display("FAIL single_en got=%b want=1", ser_en); end
    if (ser_data !== word) begin errors++; $display("FAIL single_data got=%h want=%h", ser_data, word); end
    if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid got=%0d want=2", grant_id); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", busy); end
    for (int k = 0; k < 8; k++) begin
      tick();
      sample();
      checks += 4;
      if (ser_data[8*k +: 8] !== bytes[k]) begin
        errors++; $display("FAIL single_byte%0d got=%h want=%h", k, ser_data[8*k +: 8], bytes[k]);
      end
      if (ser_data[64] !== 1'b1) begin errors++; $display("FAIL single_sign%0d got=%b want=1", k, ser_data[64]); end
      if (ser_en !== 1'b0) begin errors++; $display("FAIL single_en_low%0d got=%b want=0", k, ser_en); end
      if (busy !== exp_busy) begin errors++; $display("FAIL single_busy%0d got=%b want=%b", k, busy, exp_busy); end
    end
    tick();
  endtask

  task automatic test_all_valid();
    int prev_en, prev_gid, grants;
    prev_en = -1;
    prev_gid = -1;
    grants = 0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = {$urandom, $urandom, 1'b0} | 65'(i);
    req_valid = 4'b1111;
    for (int t = 0; t < 48; t++) begin
      sample();
      checks += 4;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL all_ready got=%b want=%b", req_ready, exp_ready); end
      if (ser_en !== exp_en) begin errors++; $display("FAIL all_en got=%b want=%b", ser_en, exp_en); end
      if (ser_data !== m_data) begin errors++; $display("FAIL all_data got=%h want=%h", ser_data, m_data); end
      if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL all_gid got=%0d want=%0d", grant_id, m_gid); end
      if (ser_en) begin
        grants++;
        if (prev_en >= 0) begin
          checks += 2;
          if (cyc - prev_en !== 8) begin errors++; $display("FAIL all_spacing got=%0d want=8", cyc - prev_en); end
          if (int'(grant_id) !== (prev_gid + 1) % N) begin
            errors++; $display("FAIL all_order got=%0d want=%0d", grant_id, (prev_gid + 1) % N);
          end
        end
        prev_en = cyc;
        prev_gid = int'(grant_id);
      end
      tick();
    end
    checks++;
    if (grants < 5) begin errors++; $display("FAIL all_grants got=%0d want>=5", grants); end
  endtask

  task automatic test_rr_skip();
    int got [$];
    int t;
    idle_wait();
    req_valid = 4'b0010;
    sample();
    tick();
    sample();
    checks++;
    if (grant_id !== 2'd1 || ser_en !== 1'b1) begin
      errors++; $display("FAIL skip_first gid=%0d en=%b want 1/1", grant_id, ser_en);
    end
    req_valid = 4'b1010;
    tick();
    t = 0;
    while (got.size() < 2 && t < 30) begin
      sample();
      checks++;
      if (ser_en !== exp_en) begin errors++; $display("FAIL skip_en got=%b want=%b", ser_en, exp_en); end
      if (ser_en) got.push_back(int'(grant_id));
      tick();
      t++;
    end
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL skip_timeout grants=%0d want=2", got.size());
    end else if (got[0] != 3 || got[1] != 1) begin
      errors++; $display("FAIL skip_order got=%0d,%0d want=3,1", got[0], got[1]);
    end
  endtask

  task automatic test_withdrawn();
    int ens;
    ens = 0;
    idle_wait();
    req_valid = 4'b0100;
    sample();
    tick();
    req_valid = '0;
    tick();
    tick();
    req_valid = 4'b0001;
    sample();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_ready_shift got=%b want=0000", req_ready); end
    tick();
    req_valid = '0;
    for (int t = 0; t < 12; t++) begin
      sample();
      checks++;
      if (req_ready !== 4'b0000 || ser_en !== 1'b0) begin
        errors++; $display("FAIL wd_idle ready=%b en=%b want 0000/0", req_ready, ser_en);
      end
      if (ser_en) ens++;
      tick();
    end
    sample();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy got=%b want=0", busy); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] word3;
    idle_wait();
    req_data[0 +: W] = {1'b1, $urandom, $urandom};
    req_valid = 4'b0001;
    sample();
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    sample();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks += 4;
    if (ser_en !== 1'b0) begin errors++; $display("FAIL rm_en got=%b want=0", ser_en); end
    if (ser_data !== 65'd0) begin errors++; $display("FAIL rm_data got=%h want=0", ser_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b want=0", busy); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL rm_gid got=%0d want=0", grant_id); end
    tick();
    tick();
    word3 = {1'b0, $urandom, $urandom};
    req_data[3*W +: W] = word3;
    req_valid = 4'b1000;
    rst_n = 1'b1;
    sample();
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL rm_ready got=%b want=1000", req_ready); end
    tick();
    req_valid = '0;
    sample();
    checks += 2;
    if (grant_id !== 2'd3 || ser_en !== 1'b1) begin
      errors++; $display("FAIL rm_grant gid=%0d en=%b want 3/1", grant_id, ser_en);
    end
    if (ser_data !== word3) begin errors++; $display("FAIL rm_word got=%h want=%h", ser_data, word3); end
    for (int k = 0; k < 8; k++) begin
      tick();
      sample();
      checks++;
      if (ser_data !== word3 || ser_en !== 1'b0) begin
        errors++; $display("FAIL rm_frame%0d data=%h en=%b want %h/0", k, ser_data, ser_en, word3);
      end
    end
    tick();
  endtask

  task automatic test_hold();
    logic [W-1:0] held;
    idle_wait();
    held = {1'b1, $urandom, $urandom};
    req_data[1*W +: W] = held;
    req_valid = 4'b0010;
    sample();
    tick();
    req_valid = '0;
    for (int k = 0; k < 9; k++) begin
      req_data[1*W +: W] = {k[0], $urandom, $urandom};
      sample();
      checks += 2;
      if (ser_data !== held) begin errors++; $display("FAIL hold_data%0d got=%h want=%h", k, ser_data, held); end
      if (ser_data[64] !== 1'b1) begin errors++; $display("FAIL hold_sign%0d got=%b want=1", k, ser_data[64]); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      req_valid = N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N; i++) req_data[i*W +: W] = {$urandom_range(0, 1) == 1, $urandom, $urandom};
      end
      sample();
      checks += 5;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready t=%0d got=%b want=%b", t, req_ready, exp_ready); end
      if (ser_en !== exp_en) begin errors++; $display("FAIL rnd_en t=%0d got=%b want=%b", t, ser_en, exp_en); end
      if (ser_data !== m_data) begin errors++; $display("FAIL rnd_data t=%0d got=%h want=%h", t, ser_data, m_data); end
      if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL rnd_gid t=%0d got=%0d want=%0d", t, grant_id, m_gid); end
      if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy t=%0d got=%b want=%b", t, busy, exp_busy); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_rr_skip();
    test_withdrawn();
    test_reset_mid();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_out_sched.md
# div_out_sched

Round-robin scheduler that shares the single result serializer (`parallel2serial`) between `N_REQ` divider result channels. Each channel presents a 65-bit signed result (bit 64 = sign, bits 63:0 = magnitude) with a valid/ready handshake. The block accepts one result at a time, issues a one-cycle `en` pulse to the serializer, and holds the 65-bit word stable for the whole 8-byte frame. It sits between the divider lanes and the output serializer, and guarantees the serializer is never re-triggered mid-frame.

## Interface
- `N_REQ`, 4: number of requesting channels, 2..8.
- `FRAME`, 8: serializer frame length in cycles (bytes per result); fixed at 8 for the current serializer.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset; shared with the serializer.
- `req_valid` in `N_REQ`: channel i has a result pending.
- `req_data` in `N_REQ*65`: channel i result in bits `[i*65 +: 65]`.
- `req_ready` out `N_REQ`: one-hot accept, combinational; a transfer occurs on an edge where `req_valid[i] & req_ready[i]`.
- `ser_en` out 1: registered one-cycle start pulse to the serializer `en`.
- `ser_data` out 65: registered word to the serializer `data_i64`; held until the next accept.
- `grant_id` out `clog2(N_REQ)`: index of the channel whose word is in `ser_data`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, SHIFT. Counter `cnt` is 3 bits wide. Pointer `ptr` has `clog2(N_REQ)` bits.
- **IDLE:**
  - Search `req_valid` starting at index `ptr` and wrapping upward; the first set bit is the winner w.
  - `req_ready` = one-hot(w) if any valid is set, else 0.
  - On the accept edge: `ser_data <= req_data[w]`, `grant_id <= w`, `ptr <= (w+1) mod N_REQ`, `ser_en <= 1`, `cnt <= 0`, state goes to SHIFT.
  - With no valid: remain in IDLE with `req_ready = 0`.
- **SHIFT:**
  - `req_ready = 0`. `ser_en` is high only in the first SHIFT cycle (`cnt = 0`).
  - `cnt` increments each cycle. On the edge where `cnt == FRAME-2`, go to IDLE.
  - SHIFT therefore lasts `FRAME-1` = 7 cycles.
- **Holding the word:** `ser_data` and `grant_id` are unchanged outside accept edges. The serializer's `sign_out` is taken directly from `data_i64[64]`, so it must be held for the full frame.
- **Handshake:**
  - `req_valid` may drop before acceptance; no transfer occurs without ready.
  - A channel whose valid stays high after its transfer is a new request. It is not granted again until other valid channels have been served.
- **Width rules:** `ser_data` is passed through bit-exact. No arithmetic is applied to the data. `ptr` wraps modulo `N_REQ`, including non-power-of-2 values.
- **Reset** (asynchronous; also applies mid-frame): state IDLE, `cnt = 0`, `ptr = 0`, `ser_en = 0`, `ser_data = 0`, `grant_id = 0`, `busy = 0`, `req_ready = 0` while `rst_n` is low. After release, the first grant searches from channel 0. The frame that was in flight is lost; the serializer resets with it.

## Timing
- Accept edge A: `ser_en` is high in the cycle after A, then low for at least 7 cycles.
- Serializer bytes appear on `data_o` in cycles A+2 .. A+9 (LSB byte first).
- Back-to-back frames:
  - IDLE is re-entered 7 cycles after the `ser_en` cycle.
  - If a request is valid then, the next `ser_en` comes exactly 8 cycles after the previous one. This is full serializer throughput, and the next `en` lands when the serializer `cnt` is 0.
- `busy` is high from the `ser_en` cycle through the last SHIFT cycle, i.e. 7 cycles per grant.
- Latency from `req_valid` rising in IDLE to `ser_en`: 1 cycle. While in SHIFT, the request waits for IDLE.
- Simultaneous valids: only one is granted per accept edge, chosen by round-robin. No combinational path from `req_valid` to `ser_en`.

## Test plan
- **Single request:**
  - Stimulus: reset; `req_valid = 4'b0100`, `req_data[2] = {1'b1, 64'h0123_4567_89AB_CDEF}`.
  - Response: `req_ready = 4'b0100` for 1 cycle; `ser_en` high 1 cycle later; `ser_data` = that word; `grant_id = 2`; `data_o` = EF, CD, AB, 89, 67, 45, 23, 01; `sign_out = 1` for all 8 bytes.
- **All channels continuously valid:**
  - Stimulus: `req_valid = 4'b1111` with distinct data per channel.
  - Response: grants 0, 1, 2, 3, 0, ...; `ser_en` pulses spaced exactly 8 cycles; never two `ser_en` within 8 cycles.
- **Round-robin skip:**
  - Stimulus: after a grant to channel 1 (`ptr = 2`), set `req_valid = 4'b1010`.
  - Response: grant 3 first, then 1.
- **Withdrawn request:**
  - Stimulus: `req_valid[0]` pulses high for 1 cycle during SHIFT, then stays low.
  - Response: no grant, no `ser_en`; returns to IDLE with `busy = 0`.
- **Reset mid-frame:**
  - Stimulus: assert `rst_n = 0` at `cnt = 3`.
  - Response: `ser_en`, `ser_data`, `busy`, `grant_id` go to 0 immediately. After release with `req_valid = 4'b1000`, `grant_id = 3` and a clean 8-byte frame follows.
- **Word hold:**
  - Stimulus: change `req_data` of the granted channel during SHIFT.
  - Response: `ser_data` and `sign_out` stay unchanged until the next accept.
